// File: rtl/ceespu_pkg.sv
// Shared ceespu definitions: data-memory controller states and bus widths.
package ceespu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam int DMEM_AW = 16;
    localparam int SRAM_AW = 15;
    localparam int SRAM_DW = 16;

    localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/ceespu_dmem_ctrl_if.sv
// CPU dmem port plus 16-bit async SRAM pins; slave is the controller's view,
// master is the view of the core and the SRAM together.
import ceespu_pkg::*;

interface ceespu_dmem_ctrl_if;
    logic                I_dmemE;
    logic [3:0]          I_dmemWe;
    logic [DMEM_AW-1:0]  I_dmemAddress;
    logic [31:0]         I_dmemWData;
    logic [31:0]         O_dmemData;
    logic                O_dmemBusy;
    logic [SRAM_AW-1:0]  O_sram_addr;
    logic [SRAM_DW-1:0]  O_sram_wdata;
    logic [SRAM_DW-1:0]  I_sram_rdata;
    logic                O_sram_ce_n;
    logic                O_sram_we_n;
    logic                O_sram_lb_n;
    logic                O_sram_ub_n;

    modport slave (
        input  I_dmemE, I_dmemWe, I_dmemAddress, I_dmemWData, I_sram_rdata,
        output O_dmemData, O_dmemBusy, O_sram_addr, O_sram_wdata,
               O_sram_ce_n, O_sram_we_n, O_sram_lb_n, O_sram_ub_n
    );

    modport master (
        output I_dmemE, I_dmemWe, I_dmemAddress, I_dmemWData, I_sram_rdata,
        input  O_dmemData, O_dmemBusy, O_sram_addr, O_sram_wdata,
               O_sram_ce_n, O_sram_we_n, O_sram_lb_n, O_sram_ub_n
    );
endinterface

// File: rtl/ceespu_dmem_ctrl.sv
// ceespu data-memory controller: 32-bit word accesses as two 16-bit SRAM phases of WAIT_STATES+1 cycles.
// Full word 2W+3 cycles busy-to-DONE, single-half write W+2; CPU stalled via O_dmemBusy.
// Optional one-entry read buffer under CEESPU_DMEM_RDBUF_EN.
import ceespu_pkg::*;

module ceespu_dmem_ctrl #(
    parameter int WAIT_STATES = 1
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    ceespu_dmem_ctrl_if.slave bus
);

    dmem_state_t        state;
    logic [3:0]         waitCnt;
    logic [DMEM_AW-1:2] addrQ;
    logic [3:0]         weQ;
    logic [31:0]        wdataQ;
    logic [31:0]        dataQ;

    logic isWrite;
    logic lastCyc;
    logic bufHit;
    logic unusedAddrBits;

    assign isWrite        = (weQ != WE_READ);
    assign lastCyc        = (waitCnt == 4'(WAIT_STATES));
    assign unusedAddrBits = ^bus.I_dmemAddress[1:0];

`ifdef CEESPU_DMEM_RDBUF_EN
    logic               bufValid;
    logic [DMEM_AW-1:2] bufTag;

    assign bufHit = bufValid && (bus.I_dmemWe == WE_READ)
                 && (bufTag == bus.I_dmemAddress[DMEM_AW-1:2]);

    // The tag always names the word currently held in dataQ: writes drop it
    // because they may have changed that word in SRAM.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bufValid <= 1'b0;
            bufTag   <= '0;
        end else if (state == IDLE && bus.I_dmemE && bus.I_dmemWe != WE_READ) begin
            bufValid <= 1'b0;
        end else if (state == HI && lastCyc && !isWrite) begin
            bufValid <= 1'b1;
            bufTag   <= addrQ;
        end
    end
`else
    assign bufHit = 1'b0;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state   <= IDLE;
            waitCnt <= '0;
            addrQ   <= '0;
            weQ     <= WE_READ;
            wdataQ  <= '0;
            dataQ   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.I_dmemE) begin
                        addrQ   <= bus.I_dmemAddress[DMEM_AW-1:2];
                        weQ     <= bus.I_dmemWe;
                        wdataQ  <= bus.I_dmemWData;
                        waitCnt <= '0;
                        if (bufHit)
                            state <= DONE;
                        else if (bus.I_dmemWe == WE_READ || bus.I_dmemWe[1:0] != 2'b00)
                            state <= LO;
                        else
                            state <= HI;
                    end
                end
                LO: begin
                    if (lastCyc) begin
                        waitCnt <= '0;
                        if (!isWrite)
                            dataQ[15:0] <= bus.I_sram_rdata;
                        state <= (!isWrite || weQ[3:2] != 2'b00) ? HI : DONE;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                HI: begin
                    if (lastCyc) begin
                        waitCnt <= '0;
                        if (!isWrite)
                            dataQ[31:16] <= bus.I_sram_rdata;
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pins decode straight from state so a reset idles them in the same cycle.
    always_comb begin
        bus.O_dmemBusy   = 1'b0;
        bus.O_sram_addr  = '0;
        bus.O_sram_wdata = '0;
        bus.O_sram_ce_n  = 1'b1;
        bus.O_sram_we_n  = 1'b1;
        bus.O_sram_lb_n  = 1'b1;
        bus.O_sram_ub_n  = 1'b1;
        case (state)
            IDLE: bus.O_dmemBusy = bus.I_dmemE;
            LO: begin
                bus.O_dmemBusy   = 1'b1;
                bus.O_sram_ce_n  = 1'b0;
                bus.O_sram_addr  = {addrQ, 1'b0};
                bus.O_sram_wdata = wdataQ[15:0];
                bus.O_sram_we_n  = !(isWrite && !lastCyc);
                bus.O_sram_lb_n  = isWrite ? !weQ[0] : 1'b0;
                bus.O_sram_ub_n  = isWrite ? !weQ[1] : 1'b0;
            end
            HI: begin
                bus.O_dmemBusy   = 1'b1;
                bus.O_sram_ce_n  = 1'b0;
                bus.O_sram_addr  = {addrQ, 1'b1};
                bus.O_sram_wdata = wdataQ[31:16];
                bus.O_sram_we_n  = !(isWrite && !lastCyc);
                bus.O_sram_lb_n  = isWrite ? !weQ[2] : 1'b0;
                bus.O_sram_ub_n  = isWrite ? !weQ[3] : 1'b0;
            end
            default: bus.O_dmemBusy = 1'b0;
        endcase
    end

    assign bus.O_dmemData = dataQ;

endmodule

// File: tb/tb_ceespu_dmem_ctrl.sv
// Directed bench for ceespu_dmem_ctrl with WAIT_STATES=1 and a behavioural 16-bit SRAM.
import ceespu_pkg::*;

module tb_ceespu_dmem_ctrl;

    logic clk;
    logic rst_n;
    ceespu_dmem_ctrl_if bus();

    ceespu_dmem_ctrl #(.WAIT_STATES(1)) dut (
        .I_clk  (clk),
        .I_rst_n(rst_n),
        .bus    (bus.slave)
    );

`ifdef CEESPU_DMEM_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];

    assign bus.I_sram_rdata = mem[bus.O_sram_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[15'h10] <= 16'h1234;
            mem[15'h11] <= 16'hABCD;
        end else if (!bus.O_sram_ce_n && !bus.O_sram_we_n) begin
            if (!bus.O_sram_lb_n) mem[bus.O_sram_addr][7:0]  <= bus.O_sram_wdata[7:0];
            if (!bus.O_sram_ub_n) mem[bus.O_sram_addr][15:8] <= bus.O_sram_wdata[15:8];
        end
    end

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          doneCyc, busyCyc, weLow, ceCyc;
    logic [14:0] firstA, lastA;
    logic        lbLast, ubLast;
    logic [31:0] dataAtDone;

    // One request; cycle 0 is the accept cycle, sampled 1 time unit after each falling edge.
    task automatic doAccess(input logic [3:0] we, input logic [15:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.I_dmemE       = 1'b1;
        bus.I_dmemWe      = we;
        bus.I_dmemAddress = addr;
        bus.I_dmemWData   = wd;
        doneCyc = -1; busyCyc = 0; weLow = 0; ceCyc = 0;
        firstA = '0; lastA = '0; lbLast = 1'b1; ubLast = 1'b1; dataAtDone = '0;
        for (int k = 0; k < 24 && doneCyc < 0; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1) begin
                    bus.I_dmemE       = 1'b0;
                    bus.I_dmemWe      = 4'hF;
                    bus.I_dmemAddress = 16'hFFFC;
                    bus.I_dmemWData   = 32'h5A5A5A5A;
                end
            end
            #1;
            if (bus.O_dmemBusy) busyCyc++;
            else if (k > 0) begin
                doneCyc    = k;
                dataAtDone = bus.O_dmemData;
            end
            if (!bus.O_sram_ce_n) begin
                if (ceCyc == 0) firstA = bus.O_sram_addr;
                lastA  = bus.O_sram_addr;
                lbLast = bus.O_sram_lb_n;
                ubLast = bus.O_sram_ub_n;
                ceCyc++;
            end
            if (!bus.O_sram_we_n) weLow++;
        end
        bus.I_dmemWe = WE_READ;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.I_dmemE = 1'b0;
        bus.I_dmemWe = WE_READ;
        bus.I_dmemAddress = '0;
        bus.I_dmemWData = '0;
        #12 rst_n = 1'b1;

        @(negedge clk); #1;
        chk("idle_busy",  32'(bus.O_dmemBusy),  32'd0);
        chk("idle_ce_n",  32'(bus.O_sram_ce_n), 32'd1);
        chk("idle_we_n",  32'(bus.O_sram_we_n), 32'd1);
        chk("idle_data",  bus.O_dmemData,       32'h0);
        chk("idle_addr",  32'(bus.O_sram_addr), 32'h0);

        doAccess(WE_READ, 16'h0020, 32'h0);
        chk("rd1_done",  doneCyc,   5);
        chk("rd1_busy",  busyCyc,   5);
        chk("rd1_first", 32'(firstA), 32'h10);
        chk("rd1_last",  32'(lastA),  32'h11);
        chk("rd1_lanes", {lbLast, ubLast}, 32'b00);
        chk("rd1_we",    weLow,     0);
        chk("rd1_data",  dataAtDone, 32'hABCD1234);

        doAccess(4'b1111, 16'h0040, 32'hDEADBEEF);
        chk("wr4_done",  doneCyc,   5);
        chk("wr4_we",    weLow,     2);
        chk("wr4_first", 32'(firstA), 32'h20);
        chk("wr4_last",  32'(lastA),  32'h21);
        chk("wr4_mlo",   32'(mem[15'h20]), 32'hBEEF);
        chk("wr4_mhi",   32'(mem[15'h21]), 32'hDEAD);
        chk("wr4_hold",  dataAtDone, 32'hABCD1234);

        doAccess(4'b0100, 16'h0040, 32'h00770000);
        chk("wrb_done",  doneCyc,   3);
        chk("wrb_ce",    ceCyc,     2);
        chk("wrb_addr",  32'(firstA), 32'h21);
        chk("wrb_lanes", {lbLast, ubLast}, 32'b01);
        chk("wrb_we",    weLow,     1);
        chk("wrb_mhi",   32'(mem[15'h21]), 32'hDE77);
        chk("wrb_mlo",   32'(mem[15'h20]), 32'hBEEF);

        // Reset during the first HI cycle (cycle 3) of a read.
        @(negedge clk);
        bus.I_dmemE = 1'b1;
        bus.I_dmemAddress = 16'h0020;
        @(negedge clk);
        bus.I_dmemE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_ce_n", 32'(bus.O_sram_ce_n), 32'd0);
        chk("mid_addr", 32'(bus.O_sram_addr), 32'h11);
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  32'(bus.O_dmemBusy), 32'd0);
        chk("rst_pins",  {bus.O_sram_ce_n, bus.O_sram_we_n, bus.O_sram_lb_n, bus.O_sram_ub_n}, 32'hF);
        chk("rst_addr",  32'(bus.O_sram_addr),  32'h0);
        chk("rst_wdata", 32'(bus.O_sram_wdata), 32'h0);
        chk("rst_data",  bus.O_dmemData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        doAccess(WE_READ, 16'h0022, 32'h0);
        chk("rd2_done", doneCyc, 5);
        chk("rd2_data", dataAtDone, 32'hABCD1234);

        doAccess(WE_READ, 16'h0021, 32'h0);
        chk("rd3_done", doneCyc, RDBUF ? 1 : 5);
        chk("rd3_ce",   ceCyc,   RDBUF ? 0 : 4);
        chk("rd3_data", dataAtDone, 32'hABCD1234);

        doAccess(4'b1111, 16'h0020, 32'h11112222);
        chk("wr5_done", doneCyc, 5);

        doAccess(WE_READ, 16'h0020, 32'h0);
        chk("rd4_done", doneCyc, 5);
        chk("rd4_ce",   ceCyc,   4);
        chk("rd4_data", dataAtDone, 32'h11112222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
